// File: rtl/dram_arb.sv
// dram_arb: round-robin multi-channel arbiter in front of a single-port word memory with a fixed-latency read pipeline
module dram_arb #(
    parameter int DW   = 16,
    parameter int AW   = 10,
    parameter int NCH  = 2,
    parameter int RLAT = 2
) (
    input  logic                    Clk1,
    input  logic                    Reset,
    input  logic [NCH-1:0]          Req,
    input  logic [NCH-1:0]          WR,
    input  logic [NCH*AW-1:0]       Addr,
    input  logic [NCH*DW-1:0]       DataIn,
    output logic [NCH-1:0]          Grant,
    output logic [DW-1:0]           DataOut,
    output logic                    RdValid,
    output logic [$clog2(NCH)-1:0]  RdCh
);
    localparam int CW = $clog2(NCH);
    logic [DW-1:0] mem [2**AW];
    logic [CW-1:0] last_grant, gidx, c;
    logic          hit, gw;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic [RLAT-1:0] pv;
    logic [DW-1:0] pd [RLAT];
    logic [CW-1:0] pc [RLAT];
    // walk channels starting just after the last winner; first requester wins
    always_comb begin
        c    = last_grant;
        gidx = '0;
        hit  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            c = (c == CW'(NCH - 1)) ? '0 : c + CW'(1);
            if (!hit && Req[c]) begin
                hit  = 1'b1;
                gidx = c;
            end
        end
    end
    assign Grant = hit ? NCH'(1) << gidx : '0;
    assign ga    = Addr[gidx*AW +: AW];
    assign gd    = DataIn[gidx*DW +: DW];
    assign gw    = WR[gidx];
    always_ff @(posedge Clk1) begin
        if (hit && gw) mem[ga] <= gd;
    end
    // memory is sampled at the granting edge so later writes cannot disturb an in-flight read
    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            last_grant <= CW'(NCH - 1);
            pv         <= '0;
            RdValid    <= 1'b0;
            DataOut    <= '0;
            RdCh       <= '0;
            for (int i = 0; i < RLAT; i++) begin
                pd[i] <= '0;
                pc[i] <= '0;
            end
        end else begin
            if (hit) last_grant <= gidx;
            pv[0] <= hit && !gw;
            pd[0] <= mem[ga];
            pc[0] <= gidx;
            for (int i = 1; i < RLAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
                pc[i] <= pc[i-1];
            end
            RdValid <= pv[RLAT-1];
            if (pv[RLAT-1]) begin
                DataOut <= pd[RLAT-1];
                RdCh    <= pc[RLAT-1];
            end
        end
    end
endmodule

// File: tb/tb_dram_arb.sv
// tb_dram_arb: directed checks of arbitration, read latency, coherence and reset on dram_arb
module tb_dram_arb;
    localparam int DW = 16, AW = 10, NCH = 2;
    logic              Clk1 = 1'b0, Reset = 1'b1;
    logic [NCH-1:0]    Req = '0, WR = '0;
    logic [NCH*AW-1:0] Addr = '0;
    logic [NCH*DW-1:0] DataIn = '0;
    logic [NCH-1:0]    g2, g1, g4;
    logic [DW-1:0]     d2, d1, d4;
    logic              v2, v1, v4;
    logic              c2, c1, c4;
    int checks = 0, errs = 0;

    dram_arb #(.DW(DW), .AW(AW), .NCH(NCH), .RLAT(2)) u2 (.Clk1(Clk1), .Reset(Reset), .Req(Req), .WR(WR),
        .Addr(Addr), .DataIn(DataIn), .Grant(g2), .DataOut(d2), .RdValid(v2), .RdCh(c2));
    dram_arb #(.DW(DW), .AW(AW), .NCH(NCH), .RLAT(1)) u1 (.Clk1(Clk1), .Reset(Reset), .Req(Req), .WR(WR),
        .Addr(Addr), .DataIn(DataIn), .Grant(g1), .DataOut(d1), .RdValid(v1), .RdCh(c1));
    dram_arb #(.DW(DW), .AW(AW), .NCH(NCH), .RLAT(4)) u4 (.Clk1(Clk1), .Reset(Reset), .Req(Req), .WR(WR),
        .Addr(Addr), .DataIn(DataIn), .Grant(g4), .DataOut(d4), .RdValid(v4), .RdCh(c4));

    always #5 Clk1 = ~Clk1;

    task automatic tick;
        @(posedge Clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        Req[ch]           = r;
        WR[ch]            = w;
        Addr[ch*AW +: AW] = a;
        DataIn[ch*DW +: DW] = d;
    endtask

    task automatic idle;
        Req = '0;
        WR  = '0;
    endtask

    initial begin
        tick;
        tick;
        Reset = 1'b0;
        chk("rst_valid", {29'd0, v2, v1, v4}, 32'd0);
        chk("rst_data", {16'd0, d2}, 32'd0);
        chk("rst_ch", {31'd0, c2}, 32'd0);
        chk("rst_grant_idle", {30'd0, g2}, 32'd0);
        // write 0x1234 to addr 5, then read it back on all three latencies
        drive(0, 1, 1, 10'd5, 16'h1234);
        #1 chk("a_wr_grant", {30'd0, g2}, 32'd1);
        tick;
        drive(0, 1, 0, 10'd5, 16'h0);
        #1 chk("a_rd_grant", {30'd0, g2}, 32'd1);
        tick;
        idle;
        chk("a_r0_valid", {29'd0, v1, v2, v4}, 32'd0);
        tick;
        chk("a_r1_valid", {29'd0, v1, v2, v4}, 32'b100);
        chk("a_r1_data", {16'd0, d1}, 32'h1234);
        chk("a_r1_ch", {31'd0, c1}, 32'd0);
        tick;
        chk("a_r2_valid", {29'd0, v1, v2, v4}, 32'b010);
        chk("a_r2_data", {16'd0, d2}, 32'h1234);
        chk("a_r2_ch", {31'd0, c2}, 32'd0);
        chk("a_r1_hold", {16'd0, d1}, 32'h1234);
        tick;
        chk("a_r3_valid", {29'd0, v1, v2, v4}, 32'd0);
        tick;
        chk("a_r4_valid", {29'd0, v1, v2, v4}, 32'b001);
        chk("a_r4_data", {16'd0, d4}, 32'h1234);
        tick;
        chk("a_r5_valid", {31'd0, v4}, 32'd0);
        // ch1 reads addr 7 while ch0 overwrites it next cycle
        drive(1, 1, 1, 10'd7, 16'hAAAA);
        #1 chk("b_wr_grant", {30'd0, g2}, 32'b10);
        tick;
        drive(1, 1, 0, 10'd7, 16'h0);
        #1 chk("b_rd_grant", {30'd0, g2}, 32'b10);
        tick;
        drive(1, 0, 0, 10'd0, 16'h0);
        drive(0, 1, 1, 10'd7, 16'h5555);
        #1 chk("b_ow_grant", {30'd0, g2}, 32'b01);
        tick;
        idle;
        tick;
        chk("b_valid", {31'd0, v2}, 32'd1);
        chk("b_data", {16'd0, d2}, 32'hAAAA);
        chk("b_ch", {31'd0, c2}, 32'd1);
        drive(1, 1, 0, 10'd7, 16'h0);
        tick;
        idle;
        tick;
        tick;
        chk("b_after_data", {15'd0, v2, d2}, {15'd0, 1'b1, 16'h5555});
        tick;
        // four writes then four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 10'(i), 16'(16'h10 + i));
            tick;
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(0, 1, 0, 10'(i), 16'h0);
            else idle;
            tick;
            if (i < 2) chk($sformatf("d_valid%0d", i), {31'd0, v2}, 32'd0);
            else chk($sformatf("d_burst%0d", i), {15'd0, v2, d2}, {15'd0, 1'b1, 16'(16'h10 + i - 2)});
        end
        tick;
        chk("d_end_valid", {31'd0, v2}, 32'd0);
        chk("d_hold", {16'd0, d2}, 32'h13);
        // read in flight, then reset one cycle later
        drive(1, 1, 0, 10'd5, 16'h0);
        #1 chk("e_grant", {30'd0, g2}, 32'b10);
        tick;
        idle;
        Reset = 1'b1;
        #1 chk("e_rst_data", {15'd0, v2, d2}, 32'd0);
        tick;
        Reset = 1'b0;
        tick;
        chk("e_post1", {15'd0, v2, d2}, 32'd0);
        tick;
        chk("e_post2", {15'd0, v2, d2}, 32'd0);
        // both channels requesting continuously after reset
        drive(0, 1, 0, 10'd0, 16'h0);
        drive(1, 1, 0, 10'd1, 16'h0);
        #1 chk("c_g0", {30'd0, g2}, 32'b01);
        tick;
        chk("c_g1", {30'd0, g2}, 32'b10);
        tick;
        chk("c_g2", {30'd0, g2}, 32'b01);
        tick;
        chk("c_g3", {30'd0, g2}, 32'b10);
        chk("c_v0", {14'd0, v2, c2, d2}, {14'd0, 1'b1, 1'b0, 16'h10});
        tick;
        idle;
        chk("c_v1", {14'd0, v2, c2, d2}, {14'd0, 1'b1, 1'b1, 16'h11});
        tick;
        tick;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
